// File: rtl/trace_pkg.sv
// Shared types for the writeback commit-stream checker: record layout, error codes, FSM states.
package trace_pkg;

  localparam int unsigned PC_W   = 36;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              wb_en;
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] value;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_PC        = 3'd1,
    ERR_WB_EN     = 3'd2,
    ERR_REG       = 3'd3,
    ERR_VALUE     = 3'd4,
    ERR_UNDERFLOW = 3'd5,
    ERR_LEFTOVER  = 3'd6
  } chk_err_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; exposes the head entry and the entry behind it without popping.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_c,
  output logic [WIDTH-1:0]           second_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_c   = (count_q == (AW+1)'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign count_o  = count_q;
  assign head_c   = mem_q[rd_ptr_q];
  assign second_c = mem_q[rd_ptr_q + AW'(1)];
  assign do_push  = push_i && !full_c;
  assign do_pop   = pop_i && !empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares each retired instruction against the next expected trace record and latches the first divergence.
module wb_trace_checker
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [PC_W-1:0]   exp_pc,
  input  logic              exp_wb_en,
  input  logic [REG_W-1:0]  exp_reg,
  input  logic [DATA_W-1:0] exp_value,
  input  logic              commit_valid,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic              commit_wb_en,
  input  logic [REG_W-1:0]  commit_reg,
  input  logic [DATA_W-1:0] commit_value,
  input  logic              end_of_test,
  output logic [CNT_W-1:0]  checked_count,
  output logic              halted,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [PC_W-1:0]   err_pc,
  output logic [DATA_W-1:0] err_exp_value,
  output logic [DATA_W-1:0] err_got_value
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  chk_state_e        state_q, state_d;
  chk_err_e          err_q, err_d, mis;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   err_pc_q, err_pc_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [PC_W-1:0]   mis_pc;
  logic [DATA_W-1:0] mis_exp, mis_got;

  trace_rec_t        wrec, head, second;
  logic              full, empty, push, pop;
  logic [CW-1:0]     count, occ_after;

  assign wrec = '{pc: exp_pc, wb_en: exp_wb_en, reg_idx: exp_reg, value: exp_value};
  assign exp_ready = (state_q == ST_RUN) && !full;
  assign push = exp_valid && exp_ready;
  assign pop  = commit_valid && (state_q == ST_RUN) && !empty;
  assign occ_after = count - CW'(pop);

  sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wdata_i  (wrec),
    .pop_i    (pop),
    .full_c   (full),
    .empty_c  (empty),
    .count_o  (count),
    .head_c   (head),
    .second_c (second)
  );

  // Field compare against the head in priority order; reg/value only matter for writing instructions.
  always_comb begin
    mis     = ERR_NONE;
    mis_pc  = commit_pc;
    mis_exp = '0;
    mis_got = '0;
    if (commit_valid) begin
      if (empty) begin
        mis     = ERR_UNDERFLOW;
        mis_got = commit_value;
      end else if (head.pc != commit_pc) begin
        mis     = ERR_PC;
        mis_exp = DATA_W'(head.pc);
        mis_got = DATA_W'(commit_pc);
      end else if (head.wb_en != commit_wb_en) begin
        mis     = ERR_WB_EN;
        mis_exp = DATA_W'(head.wb_en);
        mis_got = DATA_W'(commit_wb_en);
      end else if (head.wb_en && (head.reg_idx != commit_reg)) begin
        mis     = ERR_REG;
        mis_exp = DATA_W'(head.reg_idx);
        mis_got = DATA_W'(commit_reg);
      end else if (head.wb_en && (head.value != commit_value)) begin
        mis     = ERR_VALUE;
        mis_exp = head.value;
        mis_got = commit_value;
      end
    end
  end

  // Next-state: only RUN reacts; PASS/FAIL hold everything until reset.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    err_pc_d  = err_pc_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
    if (state_q == ST_RUN) begin
      if (mis != ERR_NONE) begin
        state_d   = ST_FAIL;
        err_d     = mis;
        err_pc_d  = mis_pc;
        err_exp_d = mis_exp;
        err_got_d = mis_got;
      end else begin
        if (commit_valid && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (end_of_test) begin
          if (occ_after == '0) begin
            state_d = ST_PASS;
          end else begin
            state_d  = ST_FAIL;
            err_d    = ERR_LEFTOVER;
            err_pc_d = pop ? second.pc : head.pc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      err_q     <= ERR_NONE;
      cnt_q     <= '0;
      err_pc_q  <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      err_pc_q  <= err_pc_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
    end
  end

  assign checked_count = cnt_q;
  assign halted        = (state_q != ST_RUN);
  assign pass          = (state_q == ST_PASS);
  assign err_code      = err_q;
  assign err_pc        = err_pc_q;
  assign err_exp_value = err_exp_q;
  assign err_got_value = err_got_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with hand-computed expectations.
module tb_wb_trace_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_valid, exp_ready, exp_wb_en;
  logic [35:0] exp_pc, exp_value;
  logic [4:0]  exp_reg;
  logic        commit_valid, commit_wb_en;
  logic [35:0] commit_pc, commit_value;
  logic [4:0]  commit_reg;
  logic        end_of_test;
  logic [31:0] checked_count;
  logic        halted, pass;
  logic [2:0]  err_code;
  logic [35:0] err_pc, err_exp_value, err_got_value;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_trace_checker #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc),
    .exp_wb_en(exp_wb_en), .exp_reg(exp_reg), .exp_value(exp_value),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_wb_en(commit_wb_en),
    .commit_reg(commit_reg), .commit_value(commit_value),
    .end_of_test(end_of_test), .checked_count(checked_count),
    .halted(halted), .pass(pass), .err_code(err_code), .err_pc(err_pc),
    .err_exp_value(err_exp_value), .err_got_value(err_got_value)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exp_valid = 0; exp_pc = '0; exp_wb_en = 0; exp_reg = '0; exp_value = '0;
    commit_valid = 0; commit_pc = '0; commit_wb_en = 0; commit_reg = '0; commit_value = '0;
    end_of_test = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic set_exp(input logic [35:0] pc, input logic wb, input logic [4:0] r, input logic [35:0] v);
    exp_valid = 1; exp_pc = pc; exp_wb_en = wb; exp_reg = r; exp_value = v;
  endtask

  task automatic set_commit(input logic [35:0] pc, input logic wb, input logic [4:0] r, input logic [35:0] v);
    commit_valid = 1; commit_pc = pc; commit_wb_en = wb; commit_reg = r; commit_value = v;
  endtask

  task automatic push1(input logic [35:0] pc, input logic wb, input logic [4:0] r, input logic [35:0] v);
    set_exp(pc, wb, r, v); step(); idle();
  endtask

  task automatic commit1(input logic [35:0] pc, input logic wb, input logic [4:0] r, input logic [35:0] v);
    set_commit(pc, wb, r, v); step(); idle();
  endtask

  initial begin
    do_reset();
    // Reset state
    check("rst_ready", 64'(exp_ready), 64'd1);
    check("rst_count", 64'(checked_count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_code), 64'd0);

    // 1: clean single-record pass
    push1(36'h100, 1, 5'd3, 36'h2A);
    commit1(36'h100, 1, 5'd3, 36'h2A);
    check("t1_count_mid", 64'(checked_count), 64'd1);
    check("t1_halted_mid", 64'(halted), 64'd0);
    end_of_test = 1; step(); idle();
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_err", 64'(err_code), 64'd0);
    check("t1_count", 64'(checked_count), 64'd1);
    check("t1_ready", 64'(exp_ready), 64'd0);

    // 2: value mismatch, then later commit ignored
    do_reset();
    push1(36'h100, 1, 5'd3, 36'h2A);
    commit1(36'h100, 1, 5'd3, 36'h2B);
    check("t2_err", 64'(err_code), 64'd4);
    check("t2_pc", 64'(err_pc), 64'h100);
    check("t2_exp", 64'(err_exp_value), 64'h2A);
    check("t2_got", 64'(err_got_value), 64'h2B);
    check("t2_pass", 64'(pass), 64'd0);
    check("t2_count", 64'(checked_count), 64'd0);
    commit1(36'h999, 0, 5'd1, 36'h55);
    check("t2_err_hold", 64'(err_code), 64'd4);
    check("t2_pc_hold", 64'(err_pc), 64'h100);
    check("t2_got_hold", 64'(err_got_value), 64'h2B);
    check("t2_count_hold", 64'(checked_count), 64'd0);

    // 3: underflow in the same cycle as the first push (no bypass)
    do_reset();
    set_exp(36'h200, 1, 5'd1, 36'h77);
    set_commit(36'h200, 1, 5'd1, 36'h77);
    step(); idle();
    check("t3_err", 64'(err_code), 64'd5);
    check("t3_exp", 64'(err_exp_value), 64'd0);
    check("t3_got", 64'(err_got_value), 64'h77);
    check("t3_pc", 64'(err_pc), 64'h200);
    check("t3_halted", 64'(halted), 64'd1);

    // 4: fill to full, drain, then one more record across the pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t4_ready_7", 64'(exp_ready), 64'd1);
      push1(36'h1000 + 36'(i * 4), 1, 5'(i + 1), 36'(i * 3));
    end
    check("t4_full", 64'(exp_ready), 64'd0);
    for (int i = 0; i < 8; i++) commit1(36'h1000 + 36'(i * 4), 1, 5'(i + 1), 36'(i * 3));
    check("t4_count", 64'(checked_count), 64'd8);
    check("t4_ready", 64'(exp_ready), 64'd1);
    check("t4_err", 64'(err_code), 64'd0);
    push1(36'h2000, 1, 5'd9, 36'hABC);
    commit1(36'h2000, 1, 5'd9, 36'hABC);
    end_of_test = 1; step(); idle();
    check("t4_wrap_pass", 64'(pass), 64'd1);
    check("t4_wrap_count", 64'(checked_count), 64'd9);

    // 5: leftover record after end_of_test with same-cycle matching pop
    do_reset();
    push1(36'h300, 1, 5'd2, 36'h11);
    push1(36'h304, 1, 5'd4, 36'h22);
    set_commit(36'h300, 1, 5'd2, 36'h11);
    end_of_test = 1;
    step(); idle();
    check("t5_err", 64'(err_code), 64'd6);
    check("t5_pc", 64'(err_pc), 64'h304);
    check("t5_count", 64'(checked_count), 64'd1);
    check("t5_pass", 64'(pass), 64'd0);

    // 6: wb_en mismatch, then mid-run reset
    do_reset();
    push1(36'h400, 0, 5'd0, 36'h0);
    commit1(36'h400, 1, 5'd5, 36'h9);
    check("t6_err", 64'(err_code), 64'd2);
    check("t6_exp", 64'(err_exp_value), 64'd0);
    check("t6_got", 64'(err_got_value), 64'd1);
    rst = 1; step(); rst = 0;
    check("t6_rst_err", 64'(err_code), 64'd0);
    check("t6_rst_pc", 64'(err_pc), 64'd0);
    check("t6_rst_got", 64'(err_got_value), 64'd0);
    check("t6_rst_halted", 64'(halted), 64'd0);
    check("t6_rst_ready", 64'(exp_ready), 64'd1);

    // 7: pc mismatch
    push1(36'h500, 1, 5'd1, 36'h1);
    commit1(36'h504, 1, 5'd1, 36'h1);
    check("t7_err", 64'(err_code), 64'd1);
    check("t7_exp", 64'(err_exp_value), 64'h500);
    check("t7_got", 64'(err_got_value), 64'h504);

    // 8: reg mismatch outranks value mismatch; reg index zero-extended
    do_reset();
    push1(36'h600, 1, 5'd3, 36'h10);
    commit1(36'h600, 1, 5'd31, 36'h20);
    check("t8_err", 64'(err_code), 64'd3);
    check("t8_exp", 64'(err_exp_value), 64'd3);
    check("t8_got", 64'(err_got_value), 64'd31);

    // 9: commit mismatch outranks leftover on end_of_test
    do_reset();
    push1(36'h700, 1, 5'd1, 36'h5);
    push1(36'h704, 1, 5'd1, 36'h6);
    set_commit(36'h700, 1, 5'd1, 36'h7);
    end_of_test = 1;
    step(); idle();
    check("t9_err", 64'(err_code), 64'd4);
    check("t9_pc", 64'(err_pc), 64'h700);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Synthesizable commit-stream checker that sits directly downstream of the trace parser and beside the processor's scalar writeback stage.
- The parser pushes expected retirement records (PC, writeback enable, register, value) into an internal FIFO.
- The processor's commit port pops and compares one record per retired instruction.
- The block latches the first divergence and reports it, and reports pass/fail at end of test.

Parameters:
DEPTH, 8, expected-record FIFO depth (power of 2, >=2)
CNT_W, 32, width of checked-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exp_valid  in  1  expected record valid
exp_ready  out  1  FIFO can accept a record
exp_pc  in  36  expected PC
exp_wb_en  in  1  expected instruction writes a scalar register
exp_reg  in  5  expected destination register
exp_value  in  36  expected writeback value
commit_valid  in  1  processor retired one instruction this cycle (no backpressure)
commit_pc  in  36  retired PC
commit_wb_en  in  1  retired instruction wrote a scalar register
commit_reg  in  5  written register
commit_value  in  36  written value
end_of_test  in  1  single-cycle pulse: the parser has no more records
checked_count  out  CNT_W  records matched so far
halted  out  1  checker has left RUN
pass  out  1  test passed
err_code  out  3  0 none, 1 pc, 2 wb_en, 3 reg, 4 value, 5 underflow, 6 leftover
err_pc  out  36  commit_pc (or head exp_pc for code 6) of the first error
err_exp_value  out  36  expected value or reg at the first error (zero-extended)
err_got_value  out  36  observed value or reg at the first error (zero-extended)

Behaviour:
- Reset: FIFO empty, state RUN, all outputs 0; exp_ready is 1 the cycle after rst deasserts.
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Push: exp_ready = (state==RUN) && !full. A record is written when exp_valid && exp_ready. Fields are stored as one packed record.
- Pop: every commit_valid in RUN pops the head. There is no bypass: a record pushed in the same cycle is not visible to that commit.
- Compare against the head, in priority order: pc, then wb_en, then (only if exp_wb_en) reg, then value. The first failing field sets err_code.
  - pc: err_exp/err_got carry the PCs.
  - reg: 5-bit values zero-extended.
- Underflow: commit_valid with the FIFO empty gives code 5, err_exp_value=0, err_got_value=commit_value.
- Latency: all outputs are registered and update the cycle after the commit or end_of_test event.
- checked_count increments on each matching commit and saturates at all-ones.
- FSM RUN -> FAIL: any mismatch or underflow.
- FSM RUN -> end_of_test handling: evaluated after the same-cycle pop.
  - Occupancy after the pop is 0 and the same-cycle commit (if any) matched: go to PASS.
  - Occupancy after the pop is nonzero: go to FAIL with code 6 and err_pc = the new head PC.
  - A same-cycle commit mismatch takes precedence over code 6.
- PASS and FAIL are sticky until rst. In these states exp_ready=0, commits are ignored, and the counter freezes.
- halted = (state != RUN); pass = (state == PASS).
- Error fields capture only the first error and are never overwritten.
- Full FIFO: exp_ready=0. A push and pop in the same cycle while full is impossible by construction. A push and pop when non-full and non-empty leaves occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy uses a log2(DEPTH)+1 bit count.
- rst asserted mid-run clears the FIFO and all state within that cycle.

Decomposition:
- trace_pkg:
  - PC_W=36, DATA_W=36, REG_W=5
  - packed struct trace_rec_t {pc, wb_en, reg, value}
  - enum chk_err_e (codes above)
  - enum chk_state_e {RUN, PASS, FAIL}
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/count/head): holds trace_rec_t. The checker FSM and compare logic live in wb_trace_checker.

Test Plan:
1. Push {pc=0x000000100, wb_en=1, r3, 0x00000002A}; commit the identical record; pulse end_of_test -> checked_count=1, pass=1, halted=1, err_code=0.
2. Push {pc=0x100, wb_en=1, r3, 0x2A}; commit value 0x2B -> next cycle err_code=4, err_pc=0x100, err_exp_value=0x2A, err_got_value=0x2B, pass=0, count=0; a later commit leaves all outputs unchanged.
3. Commit with the FIFO empty, including the same cycle as the first push -> err_code=5, err_got_value=commit_value.
4. Push 8 records with no commits -> exp_ready=0 after the 8th; pop all 8 matching -> count=8, exp_ready=1.
5. Push 2 records; commit the first (matching) in the same cycle as end_of_test -> err_code=6, err_pc=the second record's PC, count=1.
6. Push {wb_en=0}; commit with wb_en=1, r5 -> err_code=2. Then assert rst mid-run -> all outputs 0 and exp_ready=1 next cycle.
